timestamp_capture: RTL and testbench

Event timestamping stage downstream of the free-running time counter. It synchronises an asynchronous event input and detects the selected edge. On each detected edge it captures the current `time_value` into a small first-word-fall-through FIFO, which the host drains with single-cycle read strobes. An optional period register reports the wrap-safe delta between consecutive captures.

---
 rtl/timestamp_capture.sv | 141 ++++++++++++++
 tb/tb_timestamp_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_capture.sv
// timestamp_capture: synchronises an asynchronous event, detects the selected
// edge and captures time_value into a first-word-fall-through FIFO.
// Optional feature macro: TIMESTAMP_CAPTURE_PERIOD_EN adds period/period_valid
// reporting the modular delta between consecutive detected edges.
module timestamp_capture #(
   parameter int BITS       = 32,
   parameter int DEPTH_BITS = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BITS-1:0]       time_value,
   input  logic                  event_in,
   input  logic                  edge_sel,
   input  logic                  rd,
   input  logic                  clr_ovf,
   output logic [BITS-1:0]       data,
   output logic                  empty,
   output logic                  full,
   output logic [DEPTH_BITS:0]   count,
   output logic                  overflow
`ifdef TIMESTAMP_CAPTURE_PERIOD_EN
   ,
   output logic [BITS-1:0]       period,
   output logic                  period_valid
`endif
);

   localparam int DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] DEPTH_CNT = (DEPTH_BITS+1)'(DEPTH);

   logic                    s1_q, s2_q, s3_q;
   logic [DEPTH_BITS-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [DEPTH_BITS:0]     cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic [BITS-1:0]         mem_q [DEPTH];

   logic edge_det, is_full, is_empty, do_rd, do_wr, drop;

   // Synchroniser plus edge history; all cleared so no edge survives reset
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= event_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   // Edge select, FIFO write/read qualification and next-state values
   always_comb begin
      edge_det = edge_sel ? (~s2_q & s3_q) : (s2_q & ~s3_q);
      is_full  = (cnt_q == DEPTH_CNT);
      is_empty = (cnt_q == '0);
      do_rd    = rd & ~is_empty;
      // A write into a full FIFO only proceeds when a pop frees the slot
      do_wr    = edge_det & (~is_full | do_rd);
      drop     = edge_det & is_full & ~do_rd;
      wp_d     = do_wr ? wp_q + DEPTH_BITS'(1) : wp_q;
      rp_d     = do_rd ? rp_q + DEPTH_BITS'(1) : rp_q;
      cnt_d    = cnt_q;
      if (do_wr && !do_rd)      cnt_d = cnt_q + (DEPTH_BITS+1)'(1);
      else if (!do_wr && do_rd) cnt_d = cnt_q - (DEPTH_BITS+1)'(1);
      // Set wins over clear
      ovf_d    = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
   end

   // Pointer, count and sticky overflow registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q  <= '0;
         rp_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Storage array; contents need no reset since data is masked when empty
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wp_q] <= time_value;
   end

   // Output decode
   always_comb begin
      data     = is_empty ? '0 : mem_q[rp_q];
      empty    = is_empty;
      full     = is_full;
      count    = cnt_q;
      overflow = ovf_q;
   end

`ifdef TIMESTAMP_CAPTURE_PERIOD_EN
   logic [BITS-1:0] last_q, last_d, per_q, per_d;
   logic            seen_q, seen_d, pv_q, pv_d;

   // Period next-state: every detected edge counts, dropped captures included
   always_comb begin
      last_d = last_q;
      per_d  = per_q;
      seen_d = seen_q;
      pv_d   = pv_q;
      if (edge_det) begin
         last_d = time_value;
         seen_d = 1'b1;
         if (seen_q) begin
            per_d = time_value - last_q;
            pv_d  = 1'b1;
         end
      end
   end

   // Period registers
   always_ff @(posedge clk) begin
      if (reset) begin
         last_q <= '0;
         per_q  <= '0;
         seen_q <= 1'b0;
         pv_q   <= 1'b0;
      end else begin
         last_q <= last_d;
         per_q  <= per_d;
         seen_q <= seen_d;
         pv_q   <= pv_d;
      end
   end

   // Period outputs
   always_comb begin
      period       = per_q;
      period_valid = pv_q;
   end
`endif

endmodule

// File: tb/tb_timestamp_capture.sv
// Testbench for timestamp_capture: directed scenarios followed by randomized
// event/read traffic, checked against a queue-based reference model.
module tb_timestamp_capture;

   localparam int BITS  = 8;
   localparam int DB    = 2;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            reset, event_in, edge_sel, rd, clr_ovf;
   logic [BITS-1:0] time_value;
   logic [BITS-1:0] data;
   logic            empty, full, overflow;
   logic [DB:0]     count;
`ifdef TIMESTAMP_CAPTURE_PERIOD_EN
   logic [BITS-1:0] period;
   logic            period_valid;
`endif

   timestamp_capture #(.BITS(BITS), .DEPTH_BITS(DB)) dut (
      .clk(clk), .reset(reset), .time_value(time_value), .event_in(event_in),
      .edge_sel(edge_sel), .rd(rd), .clr_ovf(clr_ovf), .data(data),
      .empty(empty), .full(full), .count(count), .overflow(overflow)
`ifdef TIMESTAMP_CAPTURE_PERIOD_EN
      , .period(period), .period_valid(period_valid)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: event samples from the last three edges, a queue of
   // stored timestamps, sticky overflow and period state.
   logic [BITS-1:0] mq [$];
   bit              e1, e2, e3, movf, mseen, mpv;
   logic [BITS-1:0] mlast, mper;
   bit              tv_auto;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      logic [BITS-1:0] ed;
      ed = (mq.size() > 0) ? mq[0] : '0;
      chk("data",     32'(data),     32'(ed));
      chk("empty",    32'(empty),    32'(mq.size() == 0));
      chk("full",     32'(full),     32'(mq.size() == DEPTH));
      chk("count",    32'(count),    32'(mq.size()));
      chk("overflow", 32'(overflow), 32'(movf));
`ifdef TIMESTAMP_CAPTURE_PERIOD_EN
      chk("period",       32'(period),       32'(mper));
      chk("period_valid", 32'(period_valid), 32'(mpv));
`endif
   endtask

   // One clock: model the edge using the inputs held across it, then check.
   task automatic tick();
      bit det, rde, was_full;
      logic [BITS-1:0] tv;
      @(posedge clk);
      tv = time_value;
      if (reset) begin
         mq.delete();
         e1 = 0; e2 = 0; e3 = 0;
         movf = 0; mseen = 0; mpv = 0; mlast = '0; mper = '0;
      end else begin
         // The event seen two edges ago versus three edges ago forms the edge
         det = edge_sel ? (!e2 && e3) : (e2 && !e3);
         was_full = (mq.size() == DEPTH);
         rde = rd && (mq.size() > 0);
         if (rde) void'(mq.pop_front());
         if (det && (!was_full || rde)) mq.push_back(tv);
         if (det && was_full && !rde) movf = 1;
         else if (clr_ovf) movf = 0;
         if (det) begin
            if (mseen) begin
               mper = tv - mlast;
               mpv  = 1;
            end
            mlast = tv;
            mseen = 1;
         end
         e3 = e2; e2 = e1; e1 = event_in;
      end
      #1;
      compare_all();
      if (tv_auto) time_value = time_value + 1'b1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   logic [BITS-1:0] t0;
   int hold;

   initial begin
      reset = 1; event_in = 0; edge_sel = 0; rd = 0; clr_ovf = 0;
      time_value = '0; tv_auto = 1;
      ticks(2);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_data",  32'(data),  32'd0);
      reset = 0;
      ticks(2);

      // Single rising pulse, 8 cycles high
      event_in = 1;
      t0 = time_value;
      ticks(3);
      chk("cap_latency", 32'(data), 32'(t0 + 8'd2));
      chk("cap_count",   32'(count), 32'd1);
      ticks(5);
      event_in = 0;
      ticks(3);
      rd = 1; tick(); rd = 0;
      chk("pop_empty", 32'(empty), 32'd1);

      // Five rising edges without reads -> overflow
      for (int p = 0; p < 5; p++) begin
         event_in = 1; ticks(3);
         event_in = 0; ticks(3);
      end
      chk("ovf_full",  32'(full),     32'd1);
      chk("ovf_count", 32'(count),    32'd4);
      chk("ovf_flag",  32'(overflow), 32'd1);
      rd = 1; ticks(4); rd = 0;
      clr_ovf = 1; tick(); clr_ovf = 0;
      chk("ovf_clear", 32'(overflow), 32'd0);

      // Full FIFO, pop coincident with capture
      for (int p = 0; p < 4; p++) begin
         event_in = 1; ticks(3);
         event_in = 0; ticks(3);
      end
      event_in = 1; ticks(2);
      rd = 1; tick(); rd = 0;
      chk("full_rdwr_count", 32'(count),    32'd4);
      chk("full_rdwr_ovf",   32'(overflow), 32'd0);
      event_in = 0; ticks(3);

      // Read on empty, with and without a coincident capture
      rd = 1; ticks(5); rd = 0;
      event_in = 1; ticks(2);
      rd = 1; tick(); rd = 0;
      chk("empty_rdwr_count", 32'(count), 32'd1);
      rd = 1; ticks(2); rd = 0;
      chk("empty_rd_count", 32'(count), 32'd0);
      event_in = 0; ticks(3);

      // Falling-edge capture, then reset mid-pulse
      edge_sel = 1;
      event_in = 1; ticks(3);
      chk("fall_no_rise", 32'(count), 32'd0);
      event_in = 0; ticks(3);
      chk("fall_cap", 32'(count), 32'd1);
      event_in = 1; ticks(2);
      reset = 1; tick(); reset = 0;
      ticks(3);
      chk("rst_mid_count", 32'(count), 32'd0);
      event_in = 0; ticks(4);

      // Wrap-safe period: captures at 250 then 4
      reset = 1; edge_sel = 0; tick(); reset = 0;
      tv_auto = 0;
      ticks(2);
      event_in = 1; ticks(2);
      time_value = 8'd250; tick();
`ifdef TIMESTAMP_CAPTURE_PERIOD_EN
      chk("per_first_valid", 32'(period_valid), 32'd0);
`endif
      event_in = 0; ticks(3);
      event_in = 1; ticks(2);
      time_value = 8'd4; tick();
      chk("per_second_data", 32'(count), 32'd2);
`ifdef TIMESTAMP_CAPTURE_PERIOD_EN
      chk("per_value", 32'(period),       32'd10);
      chk("per_valid", 32'(period_valid), 32'd1);
`endif
      event_in = 0; ticks(3);

      // Randomized traffic
      for (int seg = 0; seg < 200; seg++) begin
         event_in = ~event_in;
         if ($urandom_range(0, 9) == 0) edge_sel = ~edge_sel;
         hold = $urandom_range(2, 5);
         for (int i = 0; i < hold; i++) begin
            rd         = ($urandom_range(0, 3) == 0);
            clr_ovf    = ($urandom_range(0, 7) == 0);
            reset      = ($urandom_range(0, 199) == 0);
            time_value = BITS'($urandom);
            tick();
         end
      end
      reset = 0; rd = 0; clr_ovf = 0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
